// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, resolution-time
// update, registered mispredict/redirect pulse and saturating statistics counters.
module branch_predictor #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic [1:0]  res_branch_command,
   input  logic        res_condition,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   input  logic [31:0] res_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = 30 - INDEX_BITS;

   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [1:0]        ctr_d    [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [31:0]       target_d [ENTRIES];

   logic              mispredict_q, mispredict_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d;
   logic [15:0]       branch_count_q, branch_count_d;
   logic [15:0]       mispredict_count_q, mispredict_count_d;

   logic [INDEX_BITS-1:0] if_idx, res_idx;
   logic [TAG_W-1:0]      if_tag, res_tag;
   logic                  if_hit, res_hit, res_branch, mis_det;
   logic [31:0]           res_seq_pc, actual_next;
   logic                  unused_pc_bits;

   assign if_idx  = if_pc[INDEX_BITS+1:2];
   assign if_tag  = if_pc[31:INDEX_BITS+2];
   assign res_idx = res_pc[INDEX_BITS+1:2];
   assign res_tag = res_pc[31:INDEX_BITS+2];
   assign unused_pc_bits = ^{if_pc[1:0], res_pc[1:0]};

   // Lookup reads only registered state, so a same-cycle write is seen next cycle.
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

   assign res_hit    = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
   assign res_branch = res_valid && (res_branch_command != 2'b00);
   assign res_seq_pc = res_pc + 32'd4;

   always_comb begin
      mis_det     = 1'b0;
      actual_next = res_seq_pc;
      if (res_branch) begin
         actual_next = res_condition ? res_target : res_seq_pc;
         mis_det     = (res_pred_taken != res_condition) ||
                       (res_pred_taken && res_condition && (res_pred_target != res_target));
      end else if (res_valid && res_pred_taken) begin
         // A non-branch predicted taken: fall through and drop the stale entry.
         mis_det = 1'b1;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (res_branch) begin
         if (res_hit) begin
            if (res_condition) begin
               if (ctr_q[res_idx] != 2'b11) ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
               target_d[res_idx] = res_target;
            end else if (ctr_q[res_idx] != 2'b00) begin
               ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
            end
         end else if (res_condition) begin
            valid_d[res_idx]  = 1'b1;
            tag_d[res_idx]    = res_tag;
            target_d[res_idx] = res_target;
            ctr_d[res_idx]    = 2'b10;
         end
      end else if (res_valid && res_pred_taken && res_hit) begin
         valid_d[res_idx] = 1'b0;
      end
   end

   always_comb begin
      mispredict_d       = mis_det;
      redirect_pc_d      = mis_det ? actual_next : redirect_pc_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (res_branch && (branch_count_q != 16'hFFFF))
         branch_count_d = branch_count_q + 16'd1;
      if (mis_det && (mispredict_count_q != 16'hFFFF))
         mispredict_count_d = mispredict_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b00;
         end
         mispredict_q       <= 1'b0;
         redirect_pc_q      <= 32'd0;
         branch_count_q     <= 16'd0;
         mispredict_count_q <= 16'd0;
      end else begin
         valid_q            <= valid_d;
         ctr_q              <= ctr_d;
         mispredict_q       <= mispredict_d;
         redirect_pc_q      <= redirect_pc_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign mispredict       = mispredict_q;
   assign redirect_pc      = redirect_pc_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random resolutions
// checked against an abstract table model; a monitor checks every redirect pulse.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc = 32'd0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = 32'd0;
   logic [1:0]  res_branch_command = 2'b00;
   logic        res_condition = 1'b0;
   logic [31:0] res_target = 32'd0;
   logic        res_pred_taken = 1'b0;
   logic [31:0] res_pred_target = 32'd0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   branch_predictor #(.INDEX_BITS(4)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .res_valid(res_valid), .res_pc(res_pc), .res_branch_command(res_branch_command),
      .res_condition(res_condition), .res_target(res_target), .res_pred_taken(res_pred_taken),
      .res_pred_target(res_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          v;
      int unsigned tag;
      bit [31:0]   tgt;
      int          ctr;
   } ent_t;
   ent_t m_tbl[16];
   int   m_bcount, m_mcount;

   typedef struct {
      int        when;
      bit [31:0] pc;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_idx(input bit [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(input bit [31:0] pc);
      return m_tbl[m_idx(pc)].v && (m_tbl[m_idx(pc)].tag == pc / 64);
   endfunction

   function automatic bit m_pred_taken(input bit [31:0] pc);
      return m_hit(pc) && (m_tbl[m_idx(pc)].ctr >= 2);
   endfunction

   function automatic bit [31:0] m_pred_target(input bit [31:0] pc);
      return m_pred_taken(pc) ? m_tbl[m_idx(pc)].tgt : pc + 32'd4;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) begin
         m_tbl[i].v   = 1'b0;
         m_tbl[i].ctr = 0;
      end
      m_bcount = 0;
      m_mcount = 0;
   endfunction

   // Apply one resolution to the model; schedule the expected redirect pulse.
   function automatic void m_resolve(input bit v, input bit [1:0] cmd, input bit [31:0] pc,
                                     input bit cond, input bit [31:0] tgt, input bit pt,
                                     input bit [31:0] ptg, input int now);
      bit        mis, hit;
      bit [31:0] nxt;
      int        i;
      exp_t      e;
      if (!v) return;
      i   = m_idx(pc);
      hit = m_hit(pc);
      if (cmd != 2'b00) begin
         if (m_bcount < 65535) m_bcount++;
         nxt = cond ? tgt : pc + 32'd4;
         mis = (pt != cond) || (pt && cond && ptg != tgt);
         if (hit) begin
            if (cond) begin
               m_tbl[i].ctr = (m_tbl[i].ctr < 3) ? m_tbl[i].ctr + 1 : 3;
               m_tbl[i].tgt = tgt;
            end else begin
               m_tbl[i].ctr = (m_tbl[i].ctr > 0) ? m_tbl[i].ctr - 1 : 0;
            end
         end else if (cond) begin
            m_tbl[i].v   = 1'b1;
            m_tbl[i].tag = pc / 64;
            m_tbl[i].tgt = tgt;
            m_tbl[i].ctr = 2;
         end
      end else begin
         nxt = pc + 32'd4;
         mis = pt;
         if (mis && hit) m_tbl[i].v = 1'b0;
      end
      if (mis) begin
         if (m_mcount < 65535) m_mcount++;
         e.when = now + 1;
         e.pc   = nxt;
         exp_q.push_back(e);
      end
   endfunction

   // One cycle: drive at the falling edge, check lookup and counters, update the model.
   task automatic step(input bit v, input bit [1:0] cmd, input bit [31:0] pc, input bit cond,
                       input bit [31:0] tgt, input bit pt, input bit [31:0] ptg,
                       input bit [31:0] ipc);
      @(negedge clk);
      res_valid          = v;
      res_branch_command = cmd;
      res_pc             = pc;
      res_condition      = cond;
      res_target         = tgt;
      res_pred_taken     = pt;
      res_pred_target    = ptg;
      if_pc              = ipc;
      #1;
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred_taken(ipc)});
      chk("pred_target", pred_target, m_pred_target(ipc));
      chk("branch_count", {16'd0, branch_count}, m_bcount);
      chk("mispredict_count", {16'd0, mispredict_count}, m_mcount);
      m_resolve(v, cmd, pc, cond, tgt, pt, ptg, cyc);
   endtask

   task automatic idle(input bit [31:0] ipc);
      step(1'b0, 2'b00, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ipc);
   endtask

   // Assert reset shortly after a rising edge and verify the asynchronous clear.
   task automatic do_reset(input string tag);
      #1;
      rst       = 1'b1;
      res_valid = 1'b0;
      exp_q.delete();
      m_reset();
      #1;
      chk({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
      chk({tag, "_redirect"}, redirect_pc, 32'd0);
      chk({tag, "_bcount"}, {16'd0, branch_count}, 32'd0);
      chk({tag, "_mcount"}, {16'd0, mispredict_count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every pulse must match the head of the scoreboard in cycle and redirect.
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
            chk("missed_pulse_cycle", cyc, exp_q[0].when);
            void'(exp_q.pop_front());
         end
         if (mispredict) begin
            if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
               chk("redirect_pc", redirect_pc, exp_q[0].pc);
               void'(exp_q.pop_front());
            end else begin
               chk("unexpected_mispredict", {31'd0, mispredict}, 32'd0);
            end
         end else if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
            chk("missing_mispredict", {31'd0, mispredict}, 32'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   bit [31:0] pc_pool [8] = '{32'h40, 32'h440, 32'h80, 32'h1080, 32'h44, 32'hC0, 32'hFFFF_FFFC, 32'h7C};
   bit [31:0] tg_pool [4] = '{32'h100, 32'h200, 32'h300, 32'h0};

   initial begin
      bit [31:0] p, t, ptg;
      bit        pt;
      m_reset();
      @(posedge clk);
      #2;
      chk("por_bcount", {16'd0, branch_count}, 32'd0);
      chk("por_mispredict", {31'd0, mispredict}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Empty table: every lookup falls through.
      idle(32'h40);
      chk("empty_pred_target", pred_target, 32'h44);

      // First taken resolution allocates at weakly-taken.
      step(1, 2'b11, 32'h40, 1, 32'h100, 0, 32'h44, 32'h40);
      chk("same_cycle_pre_write", {31'd0, pred_taken}, 32'd0);
      idle(32'h40);
      chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_pred_target", pred_target, 32'h100);

      // Not-taken training walks the counter down and saturates at zero.
      step(1, 2'b11, 32'h40, 0, 32'h100, 1, 32'h100, 32'h40);
      step(1, 2'b11, 32'h40, 0, 32'h100, 0, 32'h44, 32'h40);
      step(1, 2'b11, 32'h40, 0, 32'h100, 0, 32'h44, 32'h40);
      idle(32'h40);
      chk("trained_down_pred", {31'd0, pred_taken}, 32'd0);

      // Wrong target on a taken JR.
      step(1, 2'b10, 32'h80, 1, 32'h200, 1, 32'h300, 32'h80);
      idle(32'h80);
      chk("jr_stored_target", pred_target, 32'h200);

      // Tag conflict eviction, then invalidation of a non-branch predicted taken.
      step(1, 2'b11, 32'h40, 1, 32'h100, 0, 32'h44, 32'h40);
      step(1, 2'b01, 32'h440, 1, 32'h500, 0, 32'h444, 32'h440);
      idle(32'h40);
      chk("evicted_pred_target", pred_target, 32'h44);
      step(1, 2'b00, 32'h440, 0, 32'h0, 1, 32'h500, 32'h440);
      idle(32'h440);
      chk("invalidated_pred", {31'd0, pred_taken}, 32'd0);

      // Random resolutions, predictions mostly taken from the model as a pipeline would.
      for (int n = 0; n < 500; n++) begin
         p = pc_pool[$urandom_range(7)];
         t = ($urandom_range(3) == 0) ? $urandom() & 32'hFFFF_FFFC : tg_pool[$urandom_range(3)];
         if ($urandom_range(9) < 7) begin
            pt  = m_pred_taken(p);
            ptg = m_pred_target(p);
         end else begin
            pt  = $urandom_range(1);
            ptg = tg_pool[$urandom_range(3)];
         end
         step(($urandom_range(4) != 0), 2'($urandom_range(3)), p, $urandom_range(1), t, pt, ptg,
              pc_pool[$urandom_range(7)]);
      end

      // Saturate both counters with back-to-back not-taken mispredicts on an absent entry.
      for (int n = 0; n < 65537; n++)
         step(1, 2'b11, 32'h3000, 0, 32'h100, 1, 32'h100, 32'h3000);
      idle(32'h3000);
      chk("sat_bcount", {16'd0, branch_count}, 32'hFFFF);
      chk("sat_mcount", {16'd0, mispredict_count}, 32'hFFFF);

      // Reset in the middle of a pulse kills it at once.
      step(1, 2'b11, 32'h40, 1, 32'h900, 0, 32'h44, 32'h40);
      @(posedge clk);
      #1;
      chk("pulse_before_reset", {31'd0, mispredict}, 32'd1);
      do_reset("midreset");
      idle(32'h80);
      chk("post_reset_pred", {31'd0, pred_taken}, 32'd0);
      chk("post_reset_target", pred_target, 32'h84);
      idle(32'h40);
      idle(32'hFFFF_FFFC);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
